// File: rtl/pw_pkg.sv
// Shared types and constants for the door-lock password controller.
package pw_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int MAX_DIGIT  = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4
  } pw_state_t;

  // Bits needed to hold a cycle count of max_cycles.
  function automatic int tmr_width(input int max_cycles);
    return (max_cycles > 1) ? $clog2(max_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/pw_timer.sv
// Loadable down-counter shared by the unlock and lockout windows.
// expired_o marks the last cycle of a window that was loaded with value_i cycles.
module pw_timer #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count is 1 so the window lasts exactly the loaded number of cycles.
  assign expired_o = (cnt_q == W'(1));

endmodule

// File: rtl/pw_check_ctrl.sv
// Keypad password entry, verification, timed unlock window and failure lockout.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no digits held; waits for the first valid digit
// ST_ENTRY   | collecting digits (up to four), clear or enter pending
// ST_CHECK   | one cycle: compare buffer against stored password
// ST_OPEN    | unlock window running, keys ignored
// ST_LOCKOUT | lockout window running, keys ignored
module pw_check_ctrl
  import pw_pkg::*;
#(
  parameter int OPEN_CYCLES    = 16,
  parameter int LOCKOUT_CYCLES = 64,
  parameter int MAX_FAIL       = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               key_valid_i,
  input  logic [DIGIT_W-1:0] key_digit_i,
  input  logic               key_enter_i,
  input  logic               key_clear_i,
  input  logic [DIGIT_W-1:0] pw0_i,
  input  logic [DIGIT_W-1:0] pw1_i,
  input  logic [DIGIT_W-1:0] pw2_i,
  input  logic [DIGIT_W-1:0] pw3_i,
  output logic               unlock_o,
  output logic               fail_pulse_o,
  output logic               locked_out_o,
  output logic [2:0]         digit_cnt_o,
  output logic [1:0]         fail_cnt_o
);

  localparam int TMR_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = tmr_width(TMR_MAX);

  pw_state_t          state_q, state_d;
  logic [DIGIT_W-1:0] entry_q [NUM_DIGITS];
  logic [DIGIT_W-1:0] entry_d [NUM_DIGITS];
  logic [DIGIT_W-1:0] pw_w    [NUM_DIGITS];
  logic [2:0]         digit_cnt_q, digit_cnt_d;
  logic [1:0]         fail_cnt_q, fail_cnt_d, fail_next;
  logic               fail_pulse_q, fail_pulse_d;
  logic               unlock_q, locked_q;
  logic               digit_ok, buf_full, pw_match;
  logic               tmr_load, tmr_expired;
  logic [TMR_W-1:0]   tmr_value;

  assign pw_w[0] = pw0_i;
  assign pw_w[1] = pw1_i;
  assign pw_w[2] = pw2_i;
  assign pw_w[3] = pw3_i;

  // A digit only counts when no higher-priority strobe arrives with it.
  assign digit_ok  = key_valid_i && !key_clear_i && !key_enter_i &&
                     (key_digit_i <= DIGIT_W'(MAX_DIGIT));
  assign buf_full  = (digit_cnt_q >= 3'(NUM_DIGITS));
  assign fail_next = fail_cnt_q + 2'd1;

  always_comb begin
    pw_match = (digit_cnt_q == 3'(NUM_DIGITS));
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (entry_q[i] != pw_w[i]) pw_match = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    digit_cnt_d  = digit_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    fail_pulse_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_value    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) entry_d[i] = entry_q[i];

    case (state_q)
      ST_IDLE: begin
        if (digit_ok) begin
          entry_d[0]  = key_digit_i;
          digit_cnt_d = 3'd1;
          state_d     = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (key_clear_i) begin
          for (int i = 0; i < NUM_DIGITS; i++) entry_d[i] = '0;
          digit_cnt_d = '0;
          state_d     = ST_IDLE;
        end else if (key_enter_i) begin
          state_d = ST_CHECK;
        end else if (digit_ok && !buf_full) begin
          entry_d[digit_cnt_q[1:0]] = key_digit_i;
          digit_cnt_d               = digit_cnt_q + 3'd1;
        end
      end
      ST_CHECK: begin
        for (int i = 0; i < NUM_DIGITS; i++) entry_d[i] = '0;
        digit_cnt_d = '0;
        if (pw_match) begin
          fail_cnt_d = '0;
          tmr_load   = 1'b1;
          tmr_value  = TMR_W'(OPEN_CYCLES);
          state_d    = ST_OPEN;
        end else begin
          fail_cnt_d   = fail_next;
          fail_pulse_d = 1'b1;
          if (fail_next == 2'(MAX_FAIL)) begin
            tmr_load  = 1'b1;
            tmr_value = TMR_W'(LOCKOUT_CYCLES);
            state_d   = ST_LOCKOUT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_OPEN: begin
        if (tmr_expired) state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (tmr_expired) begin
          fail_cnt_d = '0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      digit_cnt_q  <= '0;
      fail_cnt_q   <= '0;
      fail_pulse_q <= 1'b0;
      unlock_q     <= 1'b0;
      locked_q     <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) entry_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      digit_cnt_q  <= digit_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      fail_pulse_q <= fail_pulse_d;
      unlock_q     <= (state_d == ST_OPEN);
      locked_q     <= (state_d == ST_LOCKOUT);
      for (int i = 0; i < NUM_DIGITS; i++) entry_q[i] <= entry_d[i];
    end
  end

  pw_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (tmr_load),
    .value_i   (tmr_value),
    .expired_o (tmr_expired)
  );

  assign unlock_o     = unlock_q;
  assign fail_pulse_o = fail_pulse_q;
  assign locked_out_o = locked_q;
  assign digit_cnt_o  = digit_cnt_q;
  assign fail_cnt_o   = fail_cnt_q;

endmodule

// File: tb/tb_pw_check_ctrl.sv
// Bench for pw_check_ctrl: vector table, directed corner sequences, and
// random keypad traffic checked against a queue/countdown reference model.
module tb_pw_check_ctrl;

  localparam int OPEN = 16;
  localparam int LOCK = 64;
  localparam int MAXF = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid, key_enter, key_clear;
  logic [3:0] key_digit;
  logic [3:0] pw [4];
  logic       unlock, fail_pulse, locked_out;
  logic [2:0] digit_cnt;
  logic [1:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pw_check_ctrl #(
    .OPEN_CYCLES    (OPEN),
    .LOCKOUT_CYCLES (LOCK),
    .MAX_FAIL       (MAXF)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .key_valid_i  (key_valid),
    .key_digit_i  (key_digit),
    .key_enter_i  (key_enter),
    .key_clear_i  (key_clear),
    .pw0_i        (pw[0]),
    .pw1_i        (pw[1]),
    .pw2_i        (pw[2]),
    .pw3_i        (pw[3]),
    .unlock_o     (unlock),
    .fail_pulse_o (fail_pulse),
    .locked_out_o (locked_out),
    .digit_cnt_o  (digit_cnt),
    .fail_cnt_o   (fail_cnt)
  );

  // Reference model: digits held, remaining window cycles, pending check.
  int m_dig[$];
  int m_open, m_lock, m_fails;
  bit m_pend, m_pulse;

  function automatic void model_reset();
    m_dig.delete();
    m_open = 0; m_lock = 0; m_fails = 0; m_pend = 1'b0; m_pulse = 1'b0;
  endfunction

  function automatic void model_step();
    bit ok;
    m_pulse = 1'b0;
    if (m_open > 0) begin
      m_open--;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (m_pend) begin
      m_pend = 1'b0;
      ok = (m_dig.size() == 4);
      if (ok) for (int i = 0; i < 4; i++) if (m_dig[i] != int'(pw[i])) ok = 1'b0;
      m_dig.delete();
      if (ok) begin
        m_fails = 0;
        m_open  = OPEN;
      end else begin
        m_fails++;
        m_pulse = 1'b1;
        if (m_fails == MAXF) m_lock = LOCK;
      end
    end else if (key_clear) begin
      m_dig.delete();
    end else if (key_enter) begin
      if (m_dig.size() > 0) m_pend = 1'b1;
    end else if (key_valid && key_digit <= 4'd9 && m_dig.size() < 4) begin
      m_dig.push_back(int'(key_digit));
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string n, input int u, input int fp, input int lo,
                         input int cnt, input int fc);
    chk({n, ".unlock"},     int'(unlock),     u);
    chk({n, ".fail_pulse"}, int'(fail_pulse), fp);
    chk({n, ".locked_out"}, int'(locked_out), lo);
    chk({n, ".digit_cnt"},  int'(digit_cnt),  cnt);
    chk({n, ".fail_cnt"},   int'(fail_cnt),   fc);
  endtask

  // Drive one cycle of strobes; returns #1 after the sampling edge.
  task automatic cyc(input int v, input int d, input int e, input int c);
    key_valid = (v != 0);
    key_digit = 4'(d);
    key_enter = (e != 0);
    key_clear = (c != 0);
    @(posedge clk);
    model_step();
    #1;
    key_valid = 1'b0;
    key_enter = 1'b0;
    key_clear = 1'b0;
  endtask

  // Digits are listed most-significant nibble first.
  task automatic key_seq(input logic [19:0] digs, input int n);
    for (int i = 0; i < n; i++) cyc(1, int'(digs[4*(n-1-i) +: 4]), 0, 0);
  endtask

  task automatic window(input bit use_lock, input bit poke, output int n);
    n = 0;
    while (((use_lock ? locked_out : unlock) === 1'b1) && n < 300) begin
      n++;
      if (poke && n[0]) cyc(1, 8, 0, 0);
      else if (poke)    cyc(0, 0, 1, 0);
      else              cyc(0, 0, 0, 0);
    end
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear before any edge.
  task automatic do_async_reset(input string name);
    #2 rst_n = 1'b0;
    #1 chk_out(name, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc(0, 0, 0, 0);
  endtask

  typedef struct {
    int v, d, e, c;
    int u, fp, lo, cnt, fc;
  } vec_t;
  vec_t vecs[$];

  function automatic void add_vec(int v, int d, int e, int c,
                                  int u, int fp, int lo, int cnt, int fc);
    vec_t t;
    t.v = v; t.d = d; t.e = e; t.c = c;
    t.u = u; t.fp = fp; t.lo = lo; t.cnt = cnt; t.fc = fc;
    vecs.push_back(t);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0; key_digit = 4'd0;
    for (int i = 0; i < 4; i++) pw[i] = 4'd8;
    rst_n = 1'b0;

    //        v  d   e  c    u fp lo cnt fc
    add_vec(1, 8,  0, 0,   0, 0, 0, 1, 0);
    add_vec(1, 8,  0, 0,   0, 0, 0, 2, 0);
    add_vec(1, 8,  0, 0,   0, 0, 0, 3, 0);
    add_vec(1, 7,  0, 0,   0, 0, 0, 4, 0);
    add_vec(0, 0,  1, 0,   0, 0, 0, 4, 0);
    add_vec(0, 0,  0, 0,   0, 1, 0, 0, 1);
    add_vec(0, 0,  0, 0,   0, 0, 0, 0, 1);
    add_vec(1, 8,  0, 0,   0, 0, 0, 1, 1);
    add_vec(1, 10, 0, 0,   0, 0, 0, 1, 1);
    add_vec(1, 8,  0, 0,   0, 0, 0, 2, 1);
    add_vec(0, 0,  1, 1,   0, 0, 0, 0, 1);
    add_vec(0, 0,  0, 0,   0, 0, 0, 0, 1);
    add_vec(0, 0,  1, 0,   0, 0, 0, 0, 1);
    add_vec(0, 0,  0, 1,   0, 0, 0, 0, 1);
    add_vec(0, 0,  0, 0,   0, 0, 0, 0, 1);
    add_vec(1, 9,  0, 0,   0, 0, 0, 1, 1);
    add_vec(1, 8,  0, 0,   0, 0, 0, 2, 1);
    add_vec(1, 8,  0, 0,   0, 0, 0, 3, 1);
    add_vec(1, 8,  0, 0,   0, 0, 0, 4, 1);
    add_vec(1, 5,  0, 0,   0, 0, 0, 4, 1);
    add_vec(0, 0,  1, 0,   0, 0, 0, 4, 1);
    add_vec(0, 0,  0, 0,   0, 1, 0, 0, 2);
    add_vec(0, 0,  0, 0,   0, 0, 0, 0, 2);
    add_vec(1, 15, 0, 0,   0, 0, 0, 0, 2);
    add_vec(1, 8,  0, 0,   0, 0, 0, 1, 2);
    add_vec(1, 8,  1, 0,   0, 0, 0, 1, 2);
    add_vec(0, 0,  0, 0,   0, 1, 1, 0, 3);
    add_vec(0, 0,  0, 0,   0, 0, 1, 0, 3);

    repeat (2) @(posedge clk);
    #1 chk_out("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc(0, 0, 0, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].v, vecs[i].d, vecs[i].e, vecs[i].c);
      chk_out($sformatf("vec%0d", i), vecs[i].u, vecs[i].fp, vecs[i].lo,
              vecs[i].cnt, vecs[i].fc);
    end
    do_async_reset("rst_after_table");

    // Correct entry: unlock from N+2 for exactly OPEN cycles.
    key_seq(20'h08888, 4);
    cyc(0, 0, 1, 0);
    chk("open_n1.unlock", int'(unlock), 0);
    cyc(0, 0, 0, 0);
    chk("open_n2.unlock", int'(unlock), 1);
    chk("open_n2.fail_cnt", int'(fail_cnt), 0);
    window(1'b0, 1'b1, n);
    chk("open_len", n, OPEN);
    chk("open_after.digit_cnt", int'(digit_cnt), 0);
    cyc(1, 3, 0, 0);
    chk("open_first_key.digit_cnt", int'(digit_cnt), 1);
    cyc(0, 0, 0, 1);

    // Single wrong entry.
    key_seq(20'h08887, 4);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk_out("fail_once", 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk_out("fail_once_next", 0, 0, 0, 0, 1);

    // Two more wrong entries (one short) reach lockout.
    key_seq(20'h00888, 3);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk_out("fail_twice", 0, 1, 0, 0, 2);
    key_seq(20'h01234, 4);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk_out("lock_enter", 0, 1, 1, 0, 3);
    window(1'b1, 1'b1, n);
    chk("lock_len", n, LOCK);
    chk_out("lock_after", 0, 0, 0, 0, 0);
    cyc(1, 8, 0, 0);
    chk("lock_first_key.digit_cnt", int'(digit_cnt), 1);
    key_seq(20'h00888, 3);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk_out("lock_then_open", 1, 0, 0, 0, 0);
    window(1'b0, 1'b0, n);
    chk("lock_then_open_len", n, OPEN);

    // Fifth digit is dropped; entry still matches.
    key_seq(20'h88885, 5);
    chk("drop5.digit_cnt", int'(digit_cnt), 4);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk_out("drop5", 1, 0, 0, 0, 0);

    // Reset during the fifth OPEN cycle.
    repeat (4) cyc(0, 0, 0, 0);
    chk("rst_open_pre.unlock", int'(unlock), 1);
    do_async_reset("rst_open");
    cyc(1, 8, 0, 0);
    chk_out("rst_open_idle", 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1);

    // Reset during LOCKOUT.
    for (int k = 0; k < 3; k++) begin
      key_seq(20'h08887, 4);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
    end
    chk_out("rst_lock_pre", 0, 1, 1, 0, 3);
    repeat (10) cyc(0, 0, 0, 0);
    do_async_reset("rst_lock");
    cyc(1, 2, 0, 0);
    chk_out("rst_lock_idle", 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 4; i++) pw[i] = 4'($urandom_range(0, 9));
    do_async_reset("rnd_start");
    for (int k = 0; k < 4000; k++) begin
      int r, d, v, e, c;
      if ($urandom_range(0, 299) == 0) pw[$urandom_range(0, 3)] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 999) == 0) do_async_reset("rnd_rst");
      r = int'($urandom_range(0, 99));
      d = ($urandom_range(0, 99) < 75) ? int'(pw[m_dig.size() % 4])
                                       : int'($urandom_range(0, 15));
      v = 0; e = 0; c = 0;
      if (r < 35)      v = 1;
      else if (r < 43) e = 1;
      else if (r < 46) c = 1;
      cyc(v, d, e, c);
      chk_out("rnd", int'(m_open > 0), int'(m_pulse), int'(m_lock > 0),
              m_dig.size(), m_fails);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
